// File: rtl/pingpong_addr_gen.sv
// Read-address generator for banked sample BRAMs. It sweeps one frame across
// NUM_PORTS lanes, waits SETTLE_CYC cycles, then flips the ping-pong bank select.
module pingpong_addr_gen #(
  parameter int ADDR_W     = 12,
  parameter int NUM_PORTS  = 2,
  parameter int SETTLE_CYC = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          mode_cont,
  input  logic                          stop,
  input  logic [ADDR_W-1:0]             load,
  output logic                          clk_c,
  output logic [NUM_PORTS*ADDR_W-1:0]   addr,
  output logic [NUM_PORTS-1:0]          lane_valid,
  output logic                          busy,
  output logic                          switch,
  output logic                          frame_done
);

  localparam int BW = ADDR_W + 1;
  localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [CW-1:0] SETTLE_LAST = CW'((SETTLE_CYC > 0) ? (SETTLE_CYC - 1) : 0);
  localparam logic [BW-1:0] STEP        = BW'(NUM_PORTS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    SETTLE = 2'd2
  } state_t;

  state_t                        state_q, state_d;
  logic [BW-1:0]                 base_q, base_d;
  logic [CW-1:0]                 cnt_q, cnt_d;
  logic [ADDR_W-1:0]             load_q, load_d;
  logic                          mode_q, mode_d;
  logic                          stop_q, stop_d;
  logic                          switch_q, switch_d;
  logic                          done_q, done_d;
  logic                          busy_q, busy_d;
  logic [NUM_PORTS*ADDR_W-1:0]   addr_q, addr_d;
  logic [NUM_PORTS-1:0]          valid_q, valid_d;
  logic                          toggle_s;
  logic                          stop_eff_s;
  logic                          last_grp_s;

  // Lane k carries base+k, truncated to the BRAM address width.
  function automatic logic [NUM_PORTS*ADDR_W-1:0] lane_addrs(input logic [BW-1:0] b);
    logic [NUM_PORTS*ADDR_W-1:0] a;
    a = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      a[k*ADDR_W +: ADDR_W] = ADDR_W'(b + BW'(k));
    end
    return a;
  endfunction

  function automatic logic [NUM_PORTS-1:0] lane_mask(input logic [BW-1:0] b,
                                                     input logic [ADDR_W-1:0] len);
    logic [NUM_PORTS-1:0] m;
    m = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      m[k] = (b + BW'(k)) < {1'b0, len};
    end
    return m;
  endfunction

  assign clk_c      = ~clk;
  assign addr       = addr_q;
  assign lane_valid = valid_q;
  assign busy       = busy_q;
  assign switch     = switch_q;
  assign frame_done = done_q;

  assign stop_eff_s = stop_q | stop;
  assign last_grp_s = (base_q + STEP) >= {1'b0, load_q};

  // Next-state and next-output computation for the frame sequencer.
  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    cnt_d    = cnt_q;
    load_d   = load_q;
    mode_d   = mode_q;
    stop_d   = stop_q;
    switch_d = switch_q;
    done_d   = 1'b0;
    toggle_s = 1'b0;

    case (state_q)
      IDLE: begin
        stop_d = 1'b0;
        base_d = '0;
        if (start && (load != '0)) begin
          state_d = SCAN;
          load_d  = load;
          mode_d  = mode_cont;
        end else begin
          state_d = IDLE;
        end
      end
      SCAN: begin
        stop_d = stop_eff_s;
        if (last_grp_s) begin
          base_d = '0;
          if (SETTLE_CYC == 0) begin
            toggle_s = 1'b1;
          end else begin
            state_d = SETTLE;
            cnt_d   = SETTLE_LAST;
          end
        end else begin
          base_d = base_q + STEP;
        end
      end
      SETTLE: begin
        stop_d = stop_eff_s;
        base_d = '0;
        if (cnt_q == '0) begin
          toggle_s = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        base_d  = '0;
        stop_d  = 1'b0;
      end
    endcase

    // Frame boundary: flip the bank, then either chain a new frame or park.
    if (toggle_s) begin
      switch_d = ~switch_q;
      done_d   = 1'b1;
      stop_d   = 1'b0;
      base_d   = '0;
      if (mode_q && !stop_eff_s && (load != '0)) begin
        state_d = SCAN;
        load_d  = load;
        mode_d  = mode_cont;
      end else begin
        state_d = IDLE;
      end
    end else begin
      done_d = 1'b0;
    end

    busy_d  = (state_d != IDLE);
    addr_d  = lane_addrs(base_d);
    valid_d = (state_d == SCAN) ? lane_mask(base_d, load_d) : '0;
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      base_q   <= '0;
      cnt_q    <= '0;
      load_q   <= '0;
      mode_q   <= 1'b0;
      stop_q   <= 1'b0;
      switch_q <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      addr_q   <= lane_addrs('0);
      valid_q  <= '0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      cnt_q    <= cnt_d;
      load_q   <= load_d;
      mode_q   <= mode_d;
      stop_q   <= stop_d;
      switch_q <= switch_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      addr_q   <= addr_d;
      valid_q  <= valid_d;
    end
  end

endmodule

// File: tb/tb_pingpong_addr_gen.sv
// Bench for pingpong_addr_gen: two configurations (2 lanes/3 settle, 3 lanes/no settle)
// driven by shared directed and random stimulus, checked against a frame-schedule model.
module tb_pingpong_addr_gen;

  localparam int AW = 12;
  localparam int N0 = 2;
  localparam int S0 = 3;
  localparam int N1 = 3;
  localparam int S1 = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic mode_cont = 1'b0;
  logic stop = 1'b0;
  logic [AW-1:0] load = '0;

  logic clk_c0, clk_c1;
  logic [N0*AW-1:0] addr0;
  logic [N1*AW-1:0] addr1;
  logic [N0-1:0] lv0;
  logic [N1-1:0] lv1;
  logic busy0, busy1, sw0, sw1, fd0, fd1;

  int n_checks = 0;
  int n_errors = 0;

  int nports[2] = '{N0, N1};
  int settle[2] = '{S0, S1};
  int m_busy[2], m_len[2], m_idx[2], m_mode[2], m_stop[2], m_sw[2], m_fd[2];

  pingpong_addr_gen #(.ADDR_W(AW), .NUM_PORTS(N0), .SETTLE_CYC(S0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .mode_cont(mode_cont), .stop(stop), .load(load),
    .clk_c(clk_c0), .addr(addr0), .lane_valid(lv0), .busy(busy0), .switch(sw0),
    .frame_done(fd0));

  pingpong_addr_gen #(.ADDR_W(AW), .NUM_PORTS(N1), .SETTLE_CYC(S1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .mode_cont(mode_cont), .stop(stop), .load(load),
    .clk_c(clk_c1), .addr(addr1), .lane_valid(lv1), .busy(busy1), .switch(sw1),
    .frame_done(fd1));

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int ngroups(input int d);
    return (m_len[d] + nports[d] - 1) / nports[d];
  endfunction

  function automatic bit in_scan(input int d);
    return (m_busy[d] != 0) && (m_idx[d] < ngroups(d));
  endfunction

  function automatic logic [63:0] exp_addr(input int d);
    logic [63:0] a;
    int base;
    a = '0;
    base = in_scan(d) ? m_idx[d] * nports[d] : 0;
    for (int k = 0; k < nports[d]; k++) a[k*AW +: AW] = AW'((base + k) % (1 << AW));
    return a;
  endfunction

  function automatic logic [63:0] exp_lv(input int d);
    logic [63:0] v;
    int base;
    v = '0;
    base = m_idx[d] * nports[d];
    for (int k = 0; k < nports[d]; k++) v[k] = in_scan(d) && (base + k < m_len[d]);
    return v;
  endfunction

  task automatic check_outputs();
    check_val("d0_addr", 64'(addr0), exp_addr(0));
    check_val("d0_lane_valid", 64'(lv0), exp_lv(0));
    check_val("d0_busy", 64'(busy0), 64'(m_busy[0]));
    check_val("d0_switch", 64'(sw0), 64'(m_sw[0]));
    check_val("d0_frame_done", 64'(fd0), 64'(m_fd[0]));
    check_val("d1_addr", 64'(addr1), exp_addr(1));
    check_val("d1_lane_valid", 64'(lv1), exp_lv(1));
    check_val("d1_busy", 64'(busy1), 64'(m_busy[1]));
    check_val("d1_switch", 64'(sw1), 64'(m_sw[1]));
    check_val("d1_frame_done", 64'(fd1), 64'(m_fd[1]));
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_busy[d] = 0; m_len[d] = 0; m_idx[d] = 0; m_mode[d] = 0;
      m_stop[d] = 0; m_sw[d] = 0; m_fd[d] = 0;
    end
  endtask

  // A frame is ceil(len/N) group cycles followed by the settle cycles; the edge
  // after its final cycle flips the bank and may chain the next frame.
  task automatic model_step(input int d);
    m_fd[d] = 0;
    if (m_busy[d] == 0) begin
      if (start && (load != '0)) begin
        m_busy[d] = 1; m_len[d] = int'(load); m_idx[d] = 0; m_mode[d] = int'(mode_cont);
      end
    end else begin
      if (stop) m_stop[d] = 1;
      if (m_idx[d] + 1 < ngroups(d) + settle[d]) begin
        m_idx[d]++;
      end else begin
        m_sw[d] ^= 1;
        m_fd[d] = 1;
        if ((m_mode[d] != 0) && (m_stop[d] == 0) && (load != '0)) begin
          m_len[d] = int'(load); m_idx[d] = 0; m_mode[d] = int'(mode_cont);
        end else begin
          m_busy[d] = 0; m_idx[d] = 0; m_stop[d] = 0;
        end
      end
    end
  endtask

  task automatic cycle(input logic st, input logic mc, input logic sp, input logic [AW-1:0] ld);
    @(negedge clk);
    check_outputs();
    start = st; mode_cont = mc; stop = sp; load = ld;
    if (!rst) begin
      model_step(0);
      model_step(1);
    end
  endtask

  task automatic idle_cycles(input int n, input logic [AW-1:0] ld);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, ld);
  endtask

  initial begin
    logic [AW-1:0] rnd_ld;
    model_reset();
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, '0);
    @(negedge clk);
    rst = 1'b0;

    // one-shot frames of several lengths; load changes mid-frame are ignored
    cycle(1'b1, 1'b0, 1'b0, 12'd6);
    idle_cycles(12, 12'd9);
    cycle(1'b1, 1'b0, 1'b0, 12'd5);
    idle_cycles(10, 12'd0);
    cycle(1'b1, 1'b0, 1'b0, 12'd1);
    idle_cycles(8, 12'd0);

    // zero-length start is ignored; start pulses while busy are ignored
    cycle(1'b1, 1'b1, 1'b0, 12'd0);
    idle_cycles(3, 12'd0);
    cycle(1'b1, 1'b0, 1'b0, 12'd6);
    cycle(1'b1, 1'b1, 1'b0, 12'd15);
    cycle(1'b0, 1'b0, 1'b0, 12'd15);
    cycle(1'b1, 1'b1, 1'b0, 12'd15);
    idle_cycles(10, 12'd0);

    // full-range frame
    cycle(1'b1, 1'b0, 1'b0, 12'd4095);
    idle_cycles(2060, 12'd0);

    // continuous: load grows to 8 mid-frame, then stop during the second frame
    cycle(1'b1, 1'b1, 1'b0, 12'd4);
    idle_cycles(3, 12'd8);
    cycle(1'b0, 1'b1, 1'b0, 12'd8);
    cycle(1'b0, 1'b1, 1'b0, 12'd8);
    cycle(1'b0, 1'b1, 1'b1, 12'd8);
    idle_cycles(20, 12'd8);

    for (int i = 0; i < 2000; i++) begin
      rnd_ld = ($urandom_range(0, 4) == 0) ? '0 : AW'($urandom_range(1, 20));
      cycle($urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)),
            $urandom_range(0, 24) == 0, rnd_ld);
    end

    // drain any continuous frame, then make sure the bank select is 1 before reset
    for (int i = 0; i < 30; i++) cycle(1'b0, 1'b0, 1'b1, '0);
    cycle(1'b1, 1'b0, 1'b0, 12'd4);
    idle_cycles(10, 12'd0);
    if (m_sw[0] == 0) begin
      cycle(1'b1, 1'b0, 1'b0, 12'd4);
      idle_cycles(10, 12'd0);
    end

    // asynchronous reset in the second scan cycle
    cycle(1'b1, 1'b0, 1'b0, 12'd10);
    cycle(1'b0, 1'b0, 1'b0, 12'd10);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs();
    @(negedge clk);
    rst = 1'b0;
    idle_cycles(3, 12'd0);
    cycle(1'b1, 1'b0, 1'b0, 12'd6);
    idle_cycles(12, 12'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
